// File: rtl/spi_xfer_seq.sv
// Byte-transfer sequencer driving the system-bus master port of one SB_SPI core.
// Hides init, chip-select handling and status polling behind a single req/done handshake.
module spi_xfer_seq #(
  parameter logic [3:0]  BUS_ADDR74  = 4'b0000,
  parameter logic [7:0]  SPIBR_VAL   = 8'd5,
  parameter logic        CPOL        = 1'b0,
  parameter logic        CPHA        = 1'b0,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       hold_cs,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       done,
  output logic       err,
  output logic       rdy,
  output logic       init_done,
  output logic       sb_stbo,
  output logic       sb_rwo,
  output logic [7:0] sb_adro,
  output logic [7:0] sb_dato,
  input  logic       sb_acki,
  input  logic [7:0] sb_dati
);

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [3:0] REG_CR1  = 4'h9;
  localparam logic [3:0] REG_CR2  = 4'hA;
  localparam logic [3:0] REG_BR   = 4'hB;
  localparam logic [3:0] REG_SR   = 4'hC;
  localparam logic [3:0] REG_TXDR = 4'hD;
  localparam logic [3:0] REG_RXDR = 4'hE;
  localparam logic [3:0] REG_CSR  = 4'hF;

  localparam logic [7:0] CR1_VAL    = 8'h80;
  localparam logic [7:0] CR2_VAL    = {2'b11, 3'b000, CPOL, CPHA, 1'b0};
  localparam logic [7:0] CS_ON_VAL  = 8'h0E;
  localparam logic [7:0] CS_OFF_VAL = 8'h0F;

  typedef enum logic [3:0] {
    S_INIT_CR1, S_INIT_CR2, S_INIT_BR, S_INIT_CSR,
    S_IDLE, S_CS_ON, S_TX_POLL, S_TX_WR,
    S_RX_POLL, S_RX_RD, S_CS_OFF, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             stb_q, stb_d;
  logic             rw_q, rw_d;
  logic [7:0]       adr_q, adr_d;
  logic [7:0]       dat_q, dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_q, tx_d;
  logic             hold_q, hold_d;
  logic             pend_q, pend_d;
  logic             cs_q, cs_d;
  logic             err_q, err_d;
  logic             init_done_q, init_done_d;
  logic [7:0]       rxbuf_q, rxbuf_d;
  logic [7:0]       rx_q, rx_d;

  logic             acc_en;
  logic             acc_rw;
  logic [3:0]       acc_reg;
  logic [7:0]       acc_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT_CR1;
      stb_q       <= 1'b0;
      rw_q        <= 1'b0;
      adr_q       <= 8'h00;
      dat_q       <= 8'h00;
      cnt_q       <= '0;
      tx_q        <= 8'h00;
      hold_q      <= 1'b0;
      pend_q      <= 1'b0;
      cs_q        <= 1'b0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
      rxbuf_q     <= 8'h00;
      rx_q        <= 8'h00;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      rw_q        <= rw_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      cs_q        <= cs_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
      rxbuf_q     <= rxbuf_d;
      rx_q        <= rx_d;
    end
  end

  // Each bus-owning state describes one register access; the shared engine below runs it.
  always_comb begin
    acc_en  = 1'b1;
    acc_rw  = 1'b1;
    acc_reg = REG_SR;
    acc_dat = 8'h00;
    unique case (state_q)
      S_INIT_CR1: begin acc_reg = REG_CR1;  acc_dat = CR1_VAL;    end
      S_INIT_CR2: begin acc_reg = REG_CR2;  acc_dat = CR2_VAL;    end
      S_INIT_BR:  begin acc_reg = REG_BR;   acc_dat = SPIBR_VAL;  end
      S_INIT_CSR: begin acc_reg = REG_CSR;  acc_dat = CS_OFF_VAL; end
      S_CS_ON:    begin acc_reg = REG_CSR;  acc_dat = CS_ON_VAL;  end
      S_TX_POLL:  begin acc_rw = 1'b0;      acc_reg = REG_SR;     end
      S_TX_WR:    begin acc_reg = REG_TXDR; acc_dat = tx_q;       end
      S_RX_POLL:  begin acc_rw = 1'b0;      acc_reg = REG_SR;     end
      S_RX_RD:    begin acc_rw = 1'b0;      acc_reg = REG_RXDR;   end
      S_CS_OFF:   begin acc_reg = REG_CSR;  acc_dat = CS_OFF_VAL; end
      default:    acc_en = 1'b0;
    endcase
  end

  // Strobe is raised only from a cycle where it was low, which guarantees the idle gap.
  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    rw_d        = rw_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    hold_d      = hold_q;
    pend_d      = pend_q;
    cs_d        = cs_q;
    err_d       = err_q;
    init_done_d = init_done_q;
    rxbuf_d     = rxbuf_q;
    rx_d        = rx_q;

    if (acc_en) begin
      if (!stb_q) begin
        stb_d = 1'b1;
        rw_d  = acc_rw;
        adr_d = {BUS_ADDR74, acc_reg};
        dat_d = acc_dat;
        cnt_d = '0;
      end else if (sb_acki) begin
        stb_d = 1'b0;
        unique case (state_q)
          S_INIT_CR1: state_d = S_INIT_CR2;
          S_INIT_CR2: state_d = S_INIT_BR;
          S_INIT_BR:  state_d = S_INIT_CSR;
          S_INIT_CSR: begin
            cs_d        = 1'b0;
            init_done_d = 1'b1;
            state_d     = pend_q ? S_CS_ON : S_IDLE;
          end
          S_CS_ON: begin
            cs_d    = 1'b1;
            state_d = S_TX_POLL;
          end
          S_TX_POLL: if (sb_dati[4]) state_d = S_TX_WR;
          S_TX_WR:   state_d = S_RX_POLL;
          S_RX_POLL: if (sb_dati[3]) state_d = S_RX_RD;
          S_RX_RD: begin
            rxbuf_d = sb_dati;
            if (hold_q) begin
              rx_d    = sb_dati;
              state_d = S_DONE;
            end else begin
              state_d = S_CS_OFF;
            end
          end
          S_CS_OFF: begin
            cs_d    = 1'b0;
            rx_d    = rxbuf_q;
            state_d = S_DONE;
          end
          default: state_d = state_q;
        endcase
      end else if (cnt_q == CNT_LAST) begin
        stb_d   = 1'b0;
        err_d   = 1'b1;
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (state_q == S_IDLE) begin
      if (req) begin
        tx_d   = tx_data;
        hold_d = hold_cs;
        err_d  = 1'b0;
        pend_d = 1'b1;
        if (!init_done_q)  state_d = S_INIT_CR1;
        else if (cs_q)     state_d = S_TX_POLL;
        else               state_d = S_CS_ON;
      end
    end else if (state_q == S_DONE) begin
      pend_d  = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_comb begin
    rdy  = (state_q == S_IDLE);
    done = (state_q == S_DONE);
  end

  assign rx_data   = rx_q;
  assign err       = err_q;
  assign init_done = init_done_q;
  assign sb_stbo   = stb_q;
  assign sb_rwo    = rw_q;
  assign sb_adro   = adr_q;
  assign sb_dato   = dat_q;

endmodule

// File: doc/spi_xfer_seq.md
Name: spi_xfer_seq

Overview:
- Sequencer that owns the system-bus master port of one SB_SPI hard core and turns single-byte client requests into the register accesses the core needs: init, CS assert, TX write, status polling, RX read, CS release.
- Sits between a simple byte-transfer client (CPU register file or flash loader) and the SB_SPI system bus. The CPU does not poll SB_SPI status itself.

Parameters:
- BUS_ADDR74, 4'b0000, upper address nibble of the target SB_SPI instance; must match that core's BUS_ADDR74.
- SPIBR_VAL, 8'd5, value written to SPIBR; SCK = clk/(SPIBR_VAL+1).
- CPOL, 1'b0, clock polarity written to SPICR2[2].
- CPHA, 1'b0, clock phase written to SPICR2[1].
- ACK_TIMEOUT, 16, max cycles stb may wait for sb_acki before the access is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req  in  1  one-cycle pulse; starts a byte transfer; ignored unless rdy=1
- hold_cs  in  1  sampled with req; 1 keeps CS0 asserted after the byte
- tx_data  in  8  byte to send, sampled with req
- rx_data  out  8  received byte, valid while done=1 and held until the next done
- done  out  1  one-cycle pulse at transfer completion
- err  out  1  sticky; set on bus timeout; cleared by the next accepted req
- rdy  out  1  high in IDLE only
- init_done  out  1  high once the init sequence has completed
- sb_stbo  out  1  bus strobe to SB_SPI
- sb_rwo  out  1  1=write, 0=read
- sb_adro  out  8  {BUS_ADDR74, reg}
- sb_dato  out  8  write data
- sb_acki  in  1  ack from SB_SPI
- sb_dati  in  8  read data from SB_SPI

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0 (rx_data=8'h00, sb_adro=8'h00).
  - State goes to INIT step 0.
  - Releasing reset mid-sequence restarts init. Any pending transfer is lost.
- Register offsets (low nibble):
  - CR1=9, CR2=A, BR=B, SR=C, TXDR=D, RXDR=E, CSR=F.
  - SR bits: TRDY=bit4, RRDY=bit3.
- Bus access rules:
  - sb_stbo, sb_rwo, sb_adro and sb_dato are registered.
  - All four are held stable from strobe assertion until the cycle sb_acki=1 is sampled.
  - sb_stbo drops on the cycle after ack.
  - At least one idle cycle (stb=0) separates accesses.
  - Read data is captured from sb_dati in the ack cycle.
- Timeout:
  - A per-access counter counts from strobe assertion.
  - If ACK_TIMEOUT cycles pass without ack: drop stb, set err, go to IDLE. CS is not touched.
  - A timeout during INIT leaves init_done=0, and init retries on the next accepted req.
- INIT: writes, in order:
  - CR1=8'h80 (enable)
  - CR2={1'b1,1'b1,3'b000,CPOL,CPHA,1'b0} (master, manual CS hold)
  - BR=SPIBR_VAL
  - CSR=8'h0F (CS deasserted)
  - Then set init_done=1 and go to IDLE.
- IDLE: rdy=1. On req, latch tx_data and hold_cs, clear err, then:
  - if CS is not yet asserted, go to CS_ON;
  - otherwise go to TX_POLL.
  - A req while rdy=0 is dropped; there is no queueing.
- CS_ON: write CSR=8'h0E, mark CS asserted.
- TX_POLL: read SR; repeat until TRDY=1.
- TX_WR: write TXDR=latched byte.
- RX_POLL: read SR; repeat until RRDY=1.
- RX_RD: read RXDR; load rx_data.
- Finish:
  - If hold_cs=0: go to CS_OFF, which writes CSR=8'h0F and marks CS deasserted.
  - Then DONE: pulse done for 1 cycle, return to IDLE.
  - done occurs after the CS_OFF write completes, never before.
- Consecutive held bytes skip CS_ON. The first byte with hold_cs=0 ends the frame.
- Polls have no iteration limit; only the per-access timeout applies.

Test Plan:
- Reset then release; model acks with 1-cycle latency.
  - Expect exactly 4 writes: adr 09/80, 0A/C0, 0B/05, 0F/0F.
  - Then init_done=1, rdy=1.
- req, tx=8'hA5, hold_cs=0; SR returns 8'h10 then 8'h08; RXDR returns 8'h3C.
  - Expect writes in this order: 0F/0E, 0D/A5, 0F/0F.
  - Expect reads of 0C, 0C, 0E.
  - Expect done pulse with rx_data=8'h3C, rdy back to 1.
- Two reqs (8'h01 hold_cs=1, then 8'h02 hold_cs=0).
  - Expect only one 0F/0E write and one 0F/0F write, the latter after the second TXDR write.
- SR returns 8'h00 five times before TRDY.
  - Expect 6 SR reads, each with stb low ≥1 cycle between them.
  - Expect no TXDR write before TRDY is seen.
- Bus never acks the TXDR write.
  - Expect stb dropped after 16 cycles, err=1, rdy=1, no done.
  - Next req clears err.
- Assert rst low during RX_POLL.
  - Expect immediate outputs=0 and init_done=0.
  - After release, the full INIT sequence repeats.
